// File: rtl/dpram_line_pkg.sv
// ----------------------------------------------------------------------------
// dpram_line_pkg
//
// Shared definitions for the dual-port line-buffer scan-out reader.
//
// Contents:
//   state_t     - reader FSM state encoding (2 bits)
//   PIX_LAT     - clocks from an accepted ce_pix to its pix_valid strobe
//   MIN_CE_GAP  - smallest ce_pix spacing that never drops a pixel
// ----------------------------------------------------------------------------
package dpram_line_pkg;

    // IDLE : no line in progress
    // WAIT : line active, waiting for the next pixel request
    // RD   : read address presented to the RAM
    // CAP  : RAM data available, captured into the pixel output registers
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RD   = 2'd2,
        CAP  = 2'd3
    } state_t;

    localparam int PIX_LAT    = 3;
    localparam int MIN_CE_GAP = 3;

endpackage

// File: rtl/dpram_line_reader.sv
// ----------------------------------------------------------------------------
// dpram_line_reader
//
// Sequential scan-out initiator for one port of a dual-port line-buffer RAM.
// A start pulse opens a line; each pixel enable then fetches the next RAM word
// and presents it on the pixel stream. With CLEAR_EN set, every word is
// overwritten with CLEAR_VAL right after it is read, so the writer on the
// other RAM port finds an empty buffer for the following line.
//
// Parameters:
//   ADDR_W     RAM address width
//   DATA_W     RAM data / pixel width
//   LINE_LEN   words per line, 1..2**ADDR_W
//   CLEAR_EN   1: write CLEAR_VAL back after each read, 0: read only
//   CLEAR_VAL  value written back when CLEAR_EN=1
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-high reset
//   start      one-clock pulse, begins a line when idle
//   ce_pix     pixel enable, requests the next word
//   busy       line in progress
//   pix_valid  one-clock strobe qualifying pix_data / pix_addr
//   pix_data   word read from the RAM
//   pix_addr   address pix_data came from
//   done       one-clock pulse together with the last pix_valid of a line
//   overrun    sticky, a ce_pix arrived while a read was in flight
//   ram_en     RAM port enable
//   ram_we     RAM port write enable
//   ram_addr   RAM port address
//   ram_wdata  RAM port write data (zero whenever ram_we is low)
//   ram_q      RAM port read data, registered, 1-clock latency
//
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module dpram_line_reader
    import dpram_line_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 8,
    parameter int                LINE_LEN  = 256,
    parameter bit                CLEAR_EN  = 1'b1,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              ce_pix,
    output logic              busy,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              done,
    output logic              overrun,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_q
);

    // Terminal pointer value. With LINE_LEN = 2**ADDR_W this is all-ones, so
    // the pointer stops there instead of wrapping.
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(LINE_LEN - 1);

    state_t            state_q,     state_d;
    logic [ADDR_W-1:0] ptr_q,       ptr_d;
    logic              busy_q,      busy_d;
    logic              pix_valid_q, pix_valid_d;
    logic [DATA_W-1:0] pix_data_q,  pix_data_d;
    logic [ADDR_W-1:0] pix_addr_q,  pix_addr_d;
    logic              done_q,      done_d;
    logic              overrun_q,   overrun_d;
    logic              ram_en_q,    ram_en_d;
    logic              ram_we_q,    ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        busy_d      = busy_q;
        overrun_d   = overrun_q;
        pix_data_d  = pix_data_q;
        pix_addr_d  = pix_addr_q;
        ram_addr_d  = ram_addr_q;
        pix_valid_d = 1'b0;
        done_d      = 1'b0;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_wdata_d = '0;

        unique case (state_q)
            IDLE: begin
                // The done cycle still belongs to the finishing line, so a
                // start coinciding with done is dropped; the earliest new line
                // begins one clock after done.
                if (start && !done_q) begin
                    ptr_d     = '0;
                    busy_d    = 1'b1;
                    overrun_d = 1'b0;
                    state_d   = WAIT;
                end
            end

            WAIT: begin
                if (ce_pix) begin
                    ram_en_d   = 1'b1;
                    ram_addr_d = ptr_q;
                    state_d    = RD;
                end
            end

            RD: begin
                // Requests during the read are not queued; the pixel is lost
                // and the condition is latched for the host.
                if (ce_pix) begin
                    overrun_d = 1'b1;
                end
                if (CLEAR_EN) begin
                    ram_en_d    = 1'b1;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = ptr_q;
                    ram_wdata_d = CLEAR_VAL;
                end
                state_d = CAP;
            end

            CAP: begin
                if (ce_pix) begin
                    overrun_d = 1'b1;
                end
                pix_data_d  = ram_q;
                pix_addr_d  = ptr_q;
                pix_valid_d = 1'b1;
                if (ptr_q == LAST_PTR) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = WAIT;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            busy_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            pix_addr_q  <= '0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            busy_q      <= busy_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            pix_addr_q  <= pix_addr_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign pix_valid = pix_valid_q;
    assign pix_data  = pix_data_q;
    assign pix_addr  = pix_addr_q;
    assign done      = done_q;
    assign overrun   = overrun_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_dpram_line_reader.sv
// ----------------------------------------------------------------------------
// tb_dpram_line_reader
//
// Three reader instances, each on its own dual-port RAM model (port A is a
// preload port, port B belongs to the reader):
//   a : LINE_LEN=8,   CLEAR_EN=1, CLEAR_VAL=00
//   b : LINE_LEN=8,   CLEAR_EN=0            (shares start/ce_pix with a)
//   c : LINE_LEN=256, CLEAR_EN=1, CLEAR_VAL=A5
// Expected pixel streams come from a request-timing model: a request is taken
// when the line is active and at least MIN_CE_GAP clocks have passed since the
// last taken request, and it appears PIX_LAT clocks later.
// ----------------------------------------------------------------------------
module tb_dpram_line_reader;
    import dpram_line_pkg::*;

    localparam logic [7:0] CLR_C = 8'hA5;

    typedef struct packed {
        int         cyc;
        logic [7:0] addr;
        logic [7:0] data;
        logic       done;
    } pix_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start_ab = 1'b0, ce_ab = 1'b0, start_c = 1'b0, ce_c = 1'b0;

    logic       busy_a, pix_valid_a, done_a, overrun_a, ram_en_a, ram_we_a;
    logic [7:0] pix_data_a, pix_addr_a, ram_addr_a, ram_wdata_a, q_a;
    logic       busy_b, pix_valid_b, done_b, overrun_b, ram_en_b, ram_we_b;
    logic [7:0] pix_data_b, pix_addr_b, ram_addr_b, ram_wdata_b, q_b;
    logic       busy_c, pix_valid_c, done_c, overrun_c, ram_en_c, ram_we_c;
    logic [7:0] pix_data_c, pix_addr_c, ram_addr_c, ram_wdata_c, q_c;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] mem_c [256];
    logic [7:0] mdl_a [256];
    logic [7:0] mdl_b [256];
    logic [7:0] mdl_c [256];

    logic       pa_we = 1'b0;
    logic [7:0] pa_addr = 8'h00, pa_wdata = 8'h00;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   ce_log [$];
    pix_t got_a [$], got_b [$], got_c [$];
    pix_t exp_a [$], exp_b [$], exp_c [$];
    bit   exp_ovr;
    bit   we_seen_b = 1'b0;
    bit   wdata_bad = 1'b0;
    int   stray_done = 0;

    dpram_line_reader #(.ADDR_W(8), .DATA_W(8), .LINE_LEN(8), .CLEAR_EN(1'b1), .CLEAR_VAL(8'h00)) dut_a (
        .clock(clock), .reset(reset), .start(start_ab), .ce_pix(ce_ab),
        .busy(busy_a), .pix_valid(pix_valid_a), .pix_data(pix_data_a), .pix_addr(pix_addr_a),
        .done(done_a), .overrun(overrun_a), .ram_en(ram_en_a), .ram_we(ram_we_a),
        .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a), .ram_q(q_a));

    dpram_line_reader #(.ADDR_W(8), .DATA_W(8), .LINE_LEN(8), .CLEAR_EN(1'b0), .CLEAR_VAL(8'h00)) dut_b (
        .clock(clock), .reset(reset), .start(start_ab), .ce_pix(ce_ab),
        .busy(busy_b), .pix_valid(pix_valid_b), .pix_data(pix_data_b), .pix_addr(pix_addr_b),
        .done(done_b), .overrun(overrun_b), .ram_en(ram_en_b), .ram_we(ram_we_b),
        .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_q(q_b));

    dpram_line_reader #(.ADDR_W(8), .DATA_W(8), .LINE_LEN(256), .CLEAR_EN(1'b1), .CLEAR_VAL(CLR_C)) dut_c (
        .clock(clock), .reset(reset), .start(start_c), .ce_pix(ce_c),
        .busy(busy_c), .pix_valid(pix_valid_c), .pix_data(pix_data_c), .pix_addr(pix_addr_c),
        .done(done_c), .overrun(overrun_c), .ram_en(ram_en_c), .ram_we(ram_we_c),
        .ram_addr(ram_addr_c), .ram_wdata(ram_wdata_c), .ram_q(q_c));

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Dual-port RAM models: port A preload, port B read-first with 1-clock q.
    always @(posedge clock) begin
        if (pa_we) begin
            mem_a[pa_addr] <= pa_wdata;
            mem_b[pa_addr] <= pa_wdata;
            mem_c[pa_addr] <= pa_wdata;
        end
        if (ram_en_a) begin
            if (ram_we_a) mem_a[ram_addr_a] <= ram_wdata_a;
            q_a <= mem_a[ram_addr_a];
        end
        if (ram_en_b) begin
            if (ram_we_b) mem_b[ram_addr_b] <= ram_wdata_b;
            q_b <= mem_b[ram_addr_b];
        end
        if (ram_en_c) begin
            if (ram_we_c) mem_c[ram_addr_c] <= ram_wdata_c;
            q_c <= mem_c[ram_addr_c];
        end
    end

    // Pixel stream monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (pix_valid_a) got_a.push_back('{cyc: cyc, addr: pix_addr_a, data: pix_data_a, done: done_a});
        if (pix_valid_b) got_b.push_back('{cyc: cyc, addr: pix_addr_b, data: pix_data_b, done: done_b});
        if (pix_valid_c) got_c.push_back('{cyc: cyc, addr: pix_addr_c, data: pix_data_c, done: done_c});
        if ((done_a && !pix_valid_a) || (done_b && !pix_valid_b) || (done_c && !pix_valid_c)) stray_done++;
        if (ram_we_b) we_seen_b = 1'b1;
        if ((!ram_we_a && ram_wdata_a != 8'h00) || (!ram_we_b && ram_wdata_b != 8'h00) ||
            (!ram_we_c && ram_wdata_c != 8'h00)) wdata_bad = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic string fmt(input pix_t p);
        return $sformatf("cyc=%0d addr=%h data=%h done=%b", p.cyc, p.addr, p.data, p.done);
    endfunction

    function automatic bit line_done(input bit is_c);
        if (is_c) return got_c.size() > 0 && got_c[got_c.size()-1].done;
        return got_a.size() > 0 && got_a[got_a.size()-1].done;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start_ab = 1'b0; ce_ab = 1'b0; start_c = 1'b0; ce_c = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Fill all three RAMs through port A; pattern=1 puts 10+i into words 0..7.
    task automatic preload(input bit pattern);
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            v = (pattern && i < 8) ? 8'(8'h10 + i) : 8'($urandom);
            pa_we = 1'b1; pa_addr = 8'(i); pa_wdata = v;
            mdl_a[i] = v; mdl_b[i] = v; mdl_c[i] = v;
            tick();
        end
        pa_we = 1'b0;
    endtask

    task automatic begin_line(input bit is_c, output int s);
        if (is_c) start_c = 1'b1; else start_ab = 1'b1;
        s = cyc;
        ce_log.delete();
        got_a.delete(); got_b.delete(); got_c.delete();
        tick();
        start_ab = 1'b0; start_c = 1'b0;
    endtask

    task automatic ce_pulse(input bit is_c);
        if (is_c) ce_c = 1'b1; else ce_ab = 1'b1;
        ce_log.push_back(cyc);
        tick();
        ce_ab = 1'b0; ce_c = 1'b0;
    endtask

    // Issue requests with random spacing until the line reports done.
    task automatic run_line(input bit is_c, input int gap_lo, input int gap_hi, input int max_ce);
        int sent = 0;
        while (!line_done(is_c) && sent < max_ce) begin
            ce_pulse(is_c);
            repeat ($urandom_range(gap_hi, gap_lo) - 1) tick();
            sent++;
        end
        n_tests++;
        if (!line_done(is_c)) begin
            n_fail++;
            $display("[TB] FAIL line_budget got no done want done within %0d requests", max_ce);
        end
        repeat (6) tick();
    endtask

    // Reference: which requests are taken, when their pixels appear, and
    // what data they carry; also applies the clear write-back to the model RAM.
    task automatic model_line(input int s, input int len, input bit is_c);
        int   last = -100;
        int   n = 0;
        pix_t t;
        exp_ovr = 1'b0;
        exp_a.delete(); exp_b.delete(); exp_c.delete();
        foreach (ce_log[k]) begin
            int c = ce_log[k];
            if (c <= s) continue;
            if (n == len && c - last >= MIN_CE_GAP) continue;
            if (c - last < MIN_CE_GAP) begin
                exp_ovr = 1'b1;
                continue;
            end
            if (is_c) begin
                exp_c.push_back('{cyc: c + PIX_LAT, addr: 8'(n), data: mdl_c[n], done: 1'b0});
                mdl_c[n] = CLR_C;
            end else begin
                exp_a.push_back('{cyc: c + PIX_LAT, addr: 8'(n), data: mdl_a[n], done: 1'b0});
                exp_b.push_back('{cyc: c + PIX_LAT, addr: 8'(n), data: mdl_b[n], done: 1'b0});
                mdl_a[n] = 8'h00;
            end
            last = c;
            n++;
        end
        if (n == len) begin
            if (is_c) begin
                t = exp_c.pop_back(); t.done = 1'b1; exp_c.push_back(t);
            end else begin
                t = exp_a.pop_back(); t.done = 1'b1; exp_a.push_back(t);
                t = exp_b.pop_back(); t.done = 1'b1; exp_b.push_back(t);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        n_tests++;
        if ({busy_a, pix_valid_a, pix_data_a, pix_addr_a, done_a, overrun_a, ram_en_a, ram_we_a, ram_addr_a, ram_wdata_a} !== '0) begin
            n_fail++; $display("[TB] FAIL reset_outputs_a got nonzero want all 0");
        end
        n_tests++;
        if ({busy_b, pix_valid_b, pix_data_b, pix_addr_b, done_b, overrun_b, ram_en_b, ram_we_b, ram_addr_b, ram_wdata_b} !== '0) begin
            n_fail++; $display("[TB] FAIL reset_outputs_b got nonzero want all 0");
        end
        n_tests++;
        if ({busy_c, pix_valid_c, pix_data_c, pix_addr_c, done_c, overrun_c, ram_en_c, ram_we_c, ram_addr_c, ram_wdata_c} !== '0) begin
            n_fail++; $display("[TB] FAIL reset_outputs_c got nonzero want all 0");
        end
        do_reset();
        // Requests while idle do nothing at all.
        ce_pulse(1'b0);
        ce_pulse(1'b0);
        repeat (4) tick();
        n_tests++;
        if ({overrun_a, busy_a, ram_en_a} !== 3'b000 || got_a.size() != 0) begin
            n_fail++; $display("[TB] FAIL idle_ce got ovr/busy/en=%b%b%b strobes=%0d want 000 0", overrun_a, busy_a, ram_en_a, got_a.size());
        end
    endtask

    task automatic test_clear_line();
        int s;
        do_reset();
        preload(1'b1);
        begin_line(1'b0, s);
        run_line(1'b0, 4, 4, 20);
        model_line(s, 8, 1'b0);
        n_tests++;
        if (got_a.size() != exp_a.size() || got_b.size() != exp_b.size()) begin
            n_fail++; $display("[TB] FAIL clear_line strobes got a=%0d b=%0d want %0d", got_a.size(), got_b.size(), exp_a.size());
        end
        foreach (exp_a[k]) begin
            n_tests++;
            if (k >= got_a.size() || got_a[k] !== exp_a[k]) begin
                n_fail++; $display("[TB] FAIL clear_line pix_a[%0d] got %s want %s", k, (k < got_a.size()) ? fmt(got_a[k]) : "none", fmt(exp_a[k]));
            end
            n_tests++;
            if (k >= got_b.size() || got_b[k] !== exp_b[k]) begin
                n_fail++; $display("[TB] FAIL clear_line pix_b[%0d] got %s want %s", k, (k < got_b.size()) ? fmt(got_b[k]) : "none", fmt(exp_b[k]));
            end
        end
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (mem_a[i] !== mdl_a[i] || mem_b[i] !== mdl_b[i]) begin
                n_fail++; $display("[TB] FAIL ram_after_line[%0d] got a=%h b=%h want a=%h b=%h", i, mem_a[i], mem_b[i], mdl_a[i], mdl_b[i]);
            end
        end
        n_tests++;
        if ({busy_a, busy_b, overrun_a, we_seen_b} !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL clear_line_flags got busy_a/busy_b/ovr_a/we_b=%b%b%b%b want 0000", busy_a, busy_b, overrun_a, we_seen_b);
        end
    endtask

    task automatic test_overrun();
        int s;
        do_reset();
        preload(1'b0);
        for (int pass = 0; pass < 2; pass++) begin
            begin_line(1'b0, s);
            run_line(1'b0, 3 - pass, 3 - pass, 40);
            model_line(s, 8, 1'b0);
            n_tests++;
            if (got_a.size() != exp_a.size()) begin
                n_fail++; $display("[TB] FAIL overrun_gap%0d strobes got %0d want %0d", 3 - pass, got_a.size(), exp_a.size());
            end
            foreach (exp_a[k]) begin
                n_tests++;
                if (k >= got_a.size() || got_a[k] !== exp_a[k] || got_b[k] !== exp_b[k]) begin
                    n_fail++; $display("[TB] FAIL overrun_gap%0d pix[%0d] got %s want %s", 3 - pass, k, (k < got_a.size()) ? fmt(got_a[k]) : "none", fmt(exp_a[k]));
                end
            end
            n_tests++;
            if (overrun_a !== exp_ovr || overrun_b !== exp_ovr) begin
                n_fail++; $display("[TB] FAIL overrun_flag_gap%0d got a=%b b=%b want %b", 3 - pass, overrun_a, overrun_b, exp_ovr);
            end
        end
        // A fresh line clears the sticky flag.
        begin_line(1'b0, s);
        n_tests++;
        if ({overrun_a, busy_a} !== 2'b01) begin
            n_fail++; $display("[TB] FAIL overrun_restart got ovr/busy=%b%b want 01", overrun_a, busy_a);
        end
    endtask

    task automatic test_random_gaps();
        int s;
        for (int rep = 0; rep < 3; rep++) begin
            do_reset();
            preload(1'b0);
            begin_line(1'b0, s);
            run_line(1'b0, 1, 6, 80);
            model_line(s, 8, 1'b0);
            n_tests++;
            if (got_a.size() != exp_a.size() || got_b.size() != exp_b.size()) begin
                n_fail++; $display("[TB] FAIL random_gaps strobes got a=%0d b=%0d want %0d", got_a.size(), got_b.size(), exp_a.size());
            end
            foreach (exp_a[k]) begin
                n_tests++;
                if (k >= got_a.size() || k >= got_b.size() || got_a[k] !== exp_a[k] || got_b[k] !== exp_b[k]) begin
                    n_fail++; $display("[TB] FAIL random_gaps pix[%0d] got %s want %s", k, (k < got_a.size()) ? fmt(got_a[k]) : "none", fmt(exp_a[k]));
                end
            end
            n_tests++;
            if (overrun_a !== exp_ovr) begin
                n_fail++; $display("[TB] FAIL random_gaps_overrun got %b want %b", overrun_a, exp_ovr);
            end
        end
    endtask

    task automatic test_start_rules();
        int s, d;
        do_reset();
        preload(1'b0);
        begin_line(1'b0, s);
        for (int i = 0; i < 8; i++) begin
            ce_pulse(1'b0);
            if (i == 2) begin
                tick(); tick();
                start_ab = 1'b1;
                tick();
                start_ab = 1'b0;
            end else if (i < 7) begin
                repeat (3) tick();
            end
        end
        d = ce_log[ce_log.size()-1] + PIX_LAT;
        for (int g = 0; g < 10 && cyc < d; g++) tick();
        start_ab = 1'b1;
        tick();
        n_tests++;
        if (busy_a !== 1'b0) begin
            n_fail++; $display("[TB] FAIL start_in_done_cycle got busy=%b want 0", busy_a);
        end
        model_line(s, 8, 1'b0);
        n_tests++;
        if (got_a.size() != exp_a.size()) begin
            n_fail++; $display("[TB] FAIL start_midline strobes got %0d want %0d", got_a.size(), exp_a.size());
        end
        foreach (exp_a[k]) begin
            n_tests++;
            if (k >= got_a.size() || got_a[k] !== exp_a[k]) begin
                n_fail++; $display("[TB] FAIL start_midline pix[%0d] got %s want %s", k, (k < got_a.size()) ? fmt(got_a[k]) : "none", fmt(exp_a[k]));
            end
        end
        // Start held into the cycle after done opens the next line.
        s = cyc;
        ce_log.delete();
        got_a.delete(); got_b.delete();
        tick();
        start_ab = 1'b0;
        n_tests++;
        if (busy_a !== 1'b1) begin
            n_fail++; $display("[TB] FAIL start_after_done got busy=%b want 1", busy_a);
        end
        run_line(1'b0, 4, 4, 20);
        model_line(s, 8, 1'b0);
        n_tests++;
        if (got_a.size() != exp_a.size()) begin
            n_fail++; $display("[TB] FAIL second_line strobes got %0d want %0d", got_a.size(), exp_a.size());
        end
        foreach (exp_a[k]) begin
            n_tests++;
            if (k >= got_a.size() || k >= got_b.size() || got_a[k] !== exp_a[k] || got_b[k] !== exp_b[k]) begin
                n_fail++; $display("[TB] FAIL second_line pix[%0d] got %s want %s", k, (k < got_a.size()) ? fmt(got_a[k]) : "none", fmt(exp_a[k]));
            end
        end
    endtask

    task automatic test_reset_mid();
        int s;
        do_reset();
        preload(1'b0);
        begin_line(1'b0, s);
        ce_pulse(1'b0);
        tick();
        n_tests++;
        if ({ram_en_a, ram_we_a, busy_a} !== 3'b111) begin
            n_fail++; $display("[TB] FAIL cap_write got en/we/busy=%b%b%b want 111", ram_en_a, ram_we_a, busy_a);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({ram_en_a, ram_we_a, busy_a, pix_valid_a} !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL async_abort got en/we/busy/valid=%b%b%b%b want 0000", ram_en_a, ram_we_a, busy_a, pix_valid_a);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_tests++;
        if (mem_a[0] !== mdl_a[0] || got_a.size() != 0) begin
            n_fail++; $display("[TB] FAIL abort_clear_lost got ram0=%h strobes=%0d want %h 0", mem_a[0], got_a.size(), mdl_a[0]);
        end
        begin_line(1'b0, s);
        run_line(1'b0, 3, 5, 30);
        model_line(s, 8, 1'b0);
        n_tests++;
        if (got_a.size() != exp_a.size()) begin
            n_fail++; $display("[TB] FAIL after_abort strobes got %0d want %0d", got_a.size(), exp_a.size());
        end
        foreach (exp_a[k]) begin
            n_tests++;
            if (k >= got_a.size() || got_a[k] !== exp_a[k]) begin
                n_fail++; $display("[TB] FAIL after_abort pix[%0d] got %s want %s", k, (k < got_a.size()) ? fmt(got_a[k]) : "none", fmt(exp_a[k]));
            end
        end
    endtask

    task automatic test_full_line();
        int s;
        do_reset();
        preload(1'b0);
        begin_line(1'b1, s);
        run_line(1'b1, 3, 4, 300);
        // Requests after done land on an idle reader.
        repeat (3) begin
            ce_pulse(1'b1);
            tick();
            tick();
        end
        repeat (4) tick();
        model_line(s, 256, 1'b1);
        n_tests++;
        if (got_c.size() != exp_c.size() || exp_c.size() != 256) begin
            n_fail++; $display("[TB] FAIL full_line strobes got %0d want %0d", got_c.size(), exp_c.size());
        end
        foreach (exp_c[k]) begin
            n_tests++;
            if (k >= got_c.size() || got_c[k] !== exp_c[k]) begin
                n_fail++; $display("[TB] FAIL full_line pix[%0d] got %s want %s", k, (k < got_c.size()) ? fmt(got_c[k]) : "none", fmt(exp_c[k]));
            end
        end
        for (int i = 0; i < 256; i++) begin
            n_tests++;
            if (mem_c[i] !== mdl_c[i]) begin
                n_fail++; $display("[TB] FAIL full_line_clear[%0d] got %h want %h", i, mem_c[i], mdl_c[i]);
            end
        end
        n_tests++;
        if ({busy_c, overrun_c} !== 2'b00 || wdata_bad || stray_done != 0) begin
            n_fail++; $display("[TB] FAIL full_line_flags got busy/ovr=%b%b wdata_bad=%b stray_done=%0d want 00 0 0", busy_c, overrun_c, wdata_bad, stray_done);
        end
    endtask

    initial begin
        test_reset();
        test_clear_line();
        test_overrun();
        test_random_gaps();
        test_start_rules();
        test_reset_mid();
        test_full_line();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
